// File: rtl/fp_adder_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Stage 1 unpacks and aligns, stage 2 adds, stage 3 normalises and packs. Rounding truncates toward zero.
module fp_adder_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   cout,
  output logic                   overflow,
  output logic                   invalid
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned AW  = MAN_W + 2;
  localparam int unsigned LZW = $clog2(AW + 1);
  localparam int unsigned EXW = EXP_W + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXW-1:0] EXP_MAX  = EXW'((1 << EXP_W) - 1);
  localparam logic signed [EXW-1:0] EXP_ZERO = '0;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Stage 1: unpack, classify, order by magnitude and align
  logic               sa, sb, za, zb, ia, ib, na, nb, a_ge;
  logic [EXP_W-1:0]   ea, eb, big_e, small_e, diff;
  logic [MAN_W-1:0]   fa, fb, big_f, small_f;
  logic [AW-1:0]      small_m;
  logic               sp, sp_inv;
  logic [W-1:0]       sp_word;

  assign sa      = A[W-1];
  assign sb      = B[W-1] ^ op_sub;
  assign ea      = A[W-2 -: EXP_W];
  assign eb      = B[W-2 -: EXP_W];
  assign fa      = A[MAN_W-1:0];
  assign fb      = B[MAN_W-1:0];
  assign za      = (ea == '0);
  assign zb      = (eb == '0);
  assign ia      = (ea == '1) && (fa == '0);
  assign ib      = (eb == '1) && (fb == '0);
  assign na      = (ea == '1) && (fa != '0);
  assign nb      = (eb == '1) && (fb != '0);
  assign a_ge    = (A[W-2:0] >= B[W-2:0]);
  assign big_e   = a_ge ? ea : eb;
  assign small_e = a_ge ? eb : ea;
  assign big_f   = a_ge ? fa : fb;
  assign small_f = a_ge ? fb : fa;
  assign diff    = big_e - small_e;
  assign small_m = (int'(diff) >= int'(AW)) ? '0 : ({1'b1, small_f, 1'b0} >> diff);

  // Special operands bypass the datapath with a precomputed result word
  always_comb begin
    sp      = 1'b0;
    sp_inv  = 1'b0;
    sp_word = '0;
    if (na || nb || (ia && ib && (sa != sb))) begin
      sp      = 1'b1;
      sp_inv  = 1'b1;
      sp_word = QNAN;
    end else if (ia || ib) begin
      sp      = 1'b1;
      sp_word = {(ia ? sa : sb), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (za && zb) begin
      sp      = 1'b1;
      sp_word = {(sa & sb), {(W-1){1'b0}}};
    end else if (za) begin
      sp      = 1'b1;
      sp_word = {sb, eb, fb};
    end else if (zb) begin
      sp      = 1'b1;
      sp_word = A;
    end
  end

  logic               s1_valid, s1_sp, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]       s1_sp_word;
  logic [EXP_W-1:0]   s1_exp;
  logic [AW-1:0]      s1_big, s1_small;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sp      <= 1'b0;
      s1_inv     <= 1'b0;
      s1_sign    <= 1'b0;
      s1_sub     <= 1'b0;
      s1_sp_word <= '0;
      s1_exp     <= '0;
      s1_big     <= '0;
      s1_small   <= '0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_sp      <= sp;
      s1_inv     <= sp_inv;
      s1_sign    <= a_ge ? sa : sb;
      s1_sub     <= sa ^ sb;
      s1_sp_word <= sp_word;
      s1_exp     <= big_e;
      s1_big     <= {1'b1, big_f, 1'b0};
      s1_small   <= small_m;
    end
  end

  // Stage 2: magnitude add or subtract; the larger operand is always first
  logic [AW:0] add_res;
  assign add_res = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                          : ({1'b0, s1_big} + {1'b0, s1_small});

  logic               s2_valid, s2_sp, s2_inv, s2_sign;
  logic [W-1:0]       s2_sp_word;
  logic [EXP_W-1:0]   s2_exp;
  logic [AW:0]        s2_mant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sp      <= 1'b0;
      s2_inv     <= 1'b0;
      s2_sign    <= 1'b0;
      s2_sp_word <= '0;
      s2_exp     <= '0;
      s2_mant    <= '0;
    end else if (advance) begin
      s2_valid   <= s1_valid;
      s2_sp      <= s1_sp;
      s2_inv     <= s1_inv;
      s2_sign    <= s1_sign;
      s2_sp_word <= s1_sp_word;
      s2_exp     <= s1_exp;
      s2_mant    <= add_res;
    end
  end

  // Stage 3: normalise, detect under/overflow, pack
  logic                   carry;
  logic [LZW-1:0]         lz;
  logic [MAN_W-1:0]       frac;
  logic signed [EXW-1:0]  e_res;
  logic [W-1:0]           res_word;
  logic                   res_cout, res_ovf, res_inv;

  assign carry = s2_mant[AW];

  always_comb begin
    lz = LZW'(AW);
    for (int i = 0; i < int'(AW); i++) begin
      if (s2_mant[i]) lz = LZW'(int'(AW) - 1 - i);
    end
  end

  assign frac  = carry ? MAN_W'(s2_mant >> 2)
                       : MAN_W'((s2_mant[AW-1:0] << lz) >> 1);
  assign e_res = carry ? $signed(EXW'(s2_exp) + EXW'(1'b1))
                       : $signed(EXW'(s2_exp) - EXW'(lz));

  always_comb begin
    res_word = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    res_inv  = 1'b0;
    if (s2_sp) begin
      res_word = s2_sp_word;
      res_inv  = s2_inv;
    end else if (s2_mant == '0) begin
      res_word = '0;
    end else if (e_res <= EXP_ZERO) begin
      res_word = {s2_sign, {(W-1){1'b0}}};
    end else if (e_res >= EXP_MAX) begin
      res_word = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf  = 1'b1;
      res_cout = carry;
    end else begin
      res_word = {s2_sign, e_res[EXP_W-1:0], frac};
      res_cout = carry;
    end
  end

  // Output register: flags are forced low whenever no result is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      sum       <= s2_valid ? res_word : '0;
      cout      <= s2_valid & res_cout;
      overflow  <= s2_valid & res_ovf;
      invalid   <= s2_valid & res_inv;
    end
  end

endmodule
